// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
// Resolves the Rn/Rm operands from the forwarding-unit selects, detects
// load-use hazards against the instruction held in EX, and registers the
// resolved operands, immediate, destination and control into ID/EX.
// Also handles branch flush, global hold and a saturating load-use bubble count.
module id_ex_operand_stage #(
   parameter int WIDTH  = 64,
   parameter int CTRL_W = 12,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [4:0]        id_Rn,
   input  logic [4:0]        id_Rm,
   input  logic [4:0]        id_Rd,
   input  logic [WIDTH-1:0]  id_rn_data,
   input  logic [WIDTH-1:0]  id_rm_data,
   input  logic [WIDTH-1:0]  id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              id_MemRead,
   input  logic [1:0]        forwardA,
   input  logic [1:0]        forwardB,
   input  logic [WIDTH-1:0]  ex_alu_result,
   input  logic [WIDTH-1:0]  mem_wb_result,
   input  logic [WIDTH-1:0]  mem_wb_link_addr,
   input  logic              flush,
   input  logic              hold,
   output logic              stall,
   output logic              ex_valid,
   output logic [WIDTH-1:0]  ex_opA,
   output logic [WIDTH-1:0]  ex_opB,
   output logic [WIDTH-1:0]  ex_imm,
   output logic [4:0]        ex_Rd,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic              ex_MemRead,
   output logic [CNT_W-1:0]  loaduse_count
);

   localparam logic [4:0]       XZR     = 5'd31;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Forwarding select decode; register 31 (XZR) always reads as zero.
   function automatic logic [WIDTH-1:0] fwd_sel(
      input logic [1:0]       sel,
      input logic [4:0]       reg_idx,
      input logic [WIDTH-1:0] rf_data,
      input logic [WIDTH-1:0] ex_data,
      input logic [WIDTH-1:0] wb_data,
      input logic [WIDTH-1:0] link_data
   );
      logic [WIDTH-1:0] v;
      if (reg_idx == XZR) begin
         v = {WIDTH{1'b0}};
      end else begin
         case (sel)
            2'b00:   v = rf_data;
            2'b10:   v = ex_data;
            2'b01:   v = wb_data;
            2'b11:   v = link_data;
            default: v = rf_data;
         endcase
      end
      return v;
   endfunction

   logic              ex_valid_q,   ex_valid_d;
   logic [WIDTH-1:0]  ex_opA_q,     ex_opA_d;
   logic [WIDTH-1:0]  ex_opB_q,     ex_opB_d;
   logic [WIDTH-1:0]  ex_imm_q,     ex_imm_d;
   logic [4:0]        ex_Rd_q,      ex_Rd_d;
   logic [CTRL_W-1:0] ex_ctrl_q,    ex_ctrl_d;
   logic              ex_MemRead_q, ex_MemRead_d;
   logic [CNT_W-1:0]  lu_count_q,   lu_count_d;

   logic [WIDTH-1:0]  opA_s;
   logic [WIDTH-1:0]  opB_s;
   logic              lu_s;

   // Operand muxes evaluated in ID.
   always_comb begin
      opA_s = fwd_sel(forwardA, id_Rn, id_rn_data, ex_alu_result, mem_wb_result, mem_wb_link_addr);
      opB_s = fwd_sel(forwardB, id_Rm, id_rm_data, ex_alu_result, mem_wb_result, mem_wb_link_addr);
   end

   // Load-use hazard: the load in EX writes a register the ID instruction reads.
   always_comb begin
      lu_s  = id_valid & ex_valid_q & ex_MemRead_q & (ex_Rd_q != XZR) &
              ((ex_Rd_q == id_Rn) | (ex_Rd_q == id_Rm));
      stall = lu_s & ~flush & ~hold & ~reset;
   end

   // Next-state selection: hold > flush > load-use bubble > normal advance.
   always_comb begin
      ex_valid_d   = ex_valid_q;
      ex_opA_d     = ex_opA_q;
      ex_opB_d     = ex_opB_q;
      ex_imm_d     = ex_imm_q;
      ex_Rd_d      = ex_Rd_q;
      ex_ctrl_d    = ex_ctrl_q;
      ex_MemRead_d = ex_MemRead_q;
      lu_count_d   = lu_count_q;
      if (hold) begin
         // Whole pipe frozen; a flush seen here is re-presented after hold drops.
         ex_valid_d   = ex_valid_q;
         lu_count_d   = lu_count_q;
      end else if (flush || lu_s) begin
         // Bubble: control cleared, data fields simply follow the muxes.
         ex_valid_d   = 1'b0;
         ex_ctrl_d    = {CTRL_W{1'b0}};
         ex_MemRead_d = 1'b0;
         ex_opA_d     = opA_s;
         ex_opB_d     = opB_s;
         ex_imm_d     = id_imm;
         ex_Rd_d      = id_Rd;
         if (!flush && (lu_count_q != CNT_MAX)) begin
            lu_count_d = lu_count_q + CNT_ONE;
         end else begin
            lu_count_d = lu_count_q;
         end
      end else begin
         // Normal advance; an invalid ID slot never carries control into EX.
         ex_valid_d   = id_valid;
         ex_opA_d     = opA_s;
         ex_opB_d     = opB_s;
         ex_imm_d     = id_imm;
         ex_Rd_d      = id_Rd;
         ex_ctrl_d    = id_valid ? id_ctrl : {CTRL_W{1'b0}};
         ex_MemRead_d = id_valid & id_MemRead;
         lu_count_d   = lu_count_q;
      end
   end

   // ID/EX pipeline register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid_q   <= 1'b0;
         ex_opA_q     <= {WIDTH{1'b0}};
         ex_opB_q     <= {WIDTH{1'b0}};
         ex_imm_q     <= {WIDTH{1'b0}};
         ex_Rd_q      <= 5'd0;
         ex_ctrl_q    <= {CTRL_W{1'b0}};
         ex_MemRead_q <= 1'b0;
         lu_count_q   <= {CNT_W{1'b0}};
      end else begin
         ex_valid_q   <= ex_valid_d;
         ex_opA_q     <= ex_opA_d;
         ex_opB_q     <= ex_opB_d;
         ex_imm_q     <= ex_imm_d;
         ex_Rd_q      <= ex_Rd_d;
         ex_ctrl_q    <= ex_ctrl_d;
         ex_MemRead_q <= ex_MemRead_d;
         lu_count_q   <= lu_count_d;
      end
   end

   assign ex_valid      = ex_valid_q;
   assign ex_opA        = ex_opA_q;
   assign ex_opB        = ex_opB_q;
   assign ex_imm        = ex_imm_q;
   assign ex_Rd         = ex_Rd_q;
   assign ex_ctrl       = ex_ctrl_q;
   assign ex_MemRead    = ex_MemRead_q;
   assign loaduse_count = lu_count_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios followed by random traffic,
// all checked against a behavioural pipeline model. A second instance with a
// 3-bit counter exercises counter saturation in a short run.
module tb_id_ex_operand_stage;
   localparam int W    = 64;
   localparam int CW   = 12;
   localparam int CNT  = 16;
   localparam int SCNT = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, id_valid, id_MemRead, flush, hold;
   logic [4:0]    id_Rn, id_Rm, id_Rd;
   logic [W-1:0]  id_rn_data, id_rm_data, id_imm;
   logic [W-1:0]  ex_alu_result, mem_wb_result, mem_wb_link_addr;
   logic [CW-1:0] id_ctrl;
   logic [1:0]    forwardA, forwardB;

   logic           stall, ex_valid, ex_MemRead;
   logic [W-1:0]   ex_opA, ex_opB, ex_imm;
   logic [4:0]     ex_Rd;
   logic [CW-1:0]  ex_ctrl;
   logic [CNT-1:0] loaduse_count;

   logic            s_stall, s_ex_valid, s_ex_MemRead;
   logic [W-1:0]    s_ex_opA, s_ex_opB, s_ex_imm;
   logic [4:0]      s_ex_Rd;
   logic [CW-1:0]   s_ex_ctrl;
   logic [SCNT-1:0] s_loaduse_count;

   id_ex_operand_stage #(.WIDTH(W), .CTRL_W(CW), .CNT_W(CNT)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_Rn(id_Rn), .id_Rm(id_Rm),
      .id_Rd(id_Rd), .id_rn_data(id_rn_data), .id_rm_data(id_rm_data), .id_imm(id_imm),
      .id_ctrl(id_ctrl), .id_MemRead(id_MemRead), .forwardA(forwardA), .forwardB(forwardB),
      .ex_alu_result(ex_alu_result), .mem_wb_result(mem_wb_result),
      .mem_wb_link_addr(mem_wb_link_addr), .flush(flush), .hold(hold), .stall(stall),
      .ex_valid(ex_valid), .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_imm(ex_imm), .ex_Rd(ex_Rd),
      .ex_ctrl(ex_ctrl), .ex_MemRead(ex_MemRead), .loaduse_count(loaduse_count));

   id_ex_operand_stage #(.WIDTH(W), .CTRL_W(CW), .CNT_W(SCNT)) dut_small (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_Rn(id_Rn), .id_Rm(id_Rm),
      .id_Rd(id_Rd), .id_rn_data(id_rn_data), .id_rm_data(id_rm_data), .id_imm(id_imm),
      .id_ctrl(id_ctrl), .id_MemRead(id_MemRead), .forwardA(forwardA), .forwardB(forwardB),
      .ex_alu_result(ex_alu_result), .mem_wb_result(mem_wb_result),
      .mem_wb_link_addr(mem_wb_link_addr), .flush(flush), .hold(hold), .stall(s_stall),
      .ex_valid(s_ex_valid), .ex_opA(s_ex_opA), .ex_opB(s_ex_opB), .ex_imm(s_ex_imm),
      .ex_Rd(s_ex_Rd), .ex_ctrl(s_ex_ctrl), .ex_MemRead(s_ex_MemRead),
      .loaduse_count(s_loaduse_count));

   int total = 0;
   int bad   = 0;

   // Reference model of the EX-side state
   logic          m_valid = 1'b0, m_mr = 1'b0, m_data_known = 1'b0;
   logic [W-1:0]  m_opA = '0, m_opB = '0, m_imm = '0;
   logic [4:0]    m_Rd = 5'd0;
   logic [CW-1:0] m_ctrl = '0;
   int            m_cnt = 0, m_scnt = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Operand value as seen by the instruction: XZR is zero, else the selected source
   function automatic logic [W-1:0] pick(input logic [4:0] r, input logic [1:0] f,
                                         input logic [W-1:0] rf);
      logic [W-1:0] srcs [4];
      srcs[0] = rf;
      srcs[1] = mem_wb_result;
      srcs[2] = ex_alu_result;
      srcs[3] = mem_wb_link_addr;
      return (r == 5'd31) ? '0 : srcs[f];
   endfunction

   // One clock: check stall against the model, clock, advance model, check outputs
   task automatic step();
      logic          hazard, exp_stall;
      logic          n_valid, n_mr, n_known;
      logic [W-1:0]  n_opA, n_opB, n_imm;
      logic [4:0]    n_Rd;
      logic [CW-1:0] n_ctrl;
      int            n_cnt, n_scnt;
      #1;
      hazard = id_valid && m_valid && m_mr && (m_Rd != 5'd31) && (m_Rd == id_Rn || m_Rd == id_Rm);
      exp_stall = hazard && !flush && !hold && !reset;
      check("stall", {63'd0, stall}, {63'd0, exp_stall});
      check("stall_small", {63'd0, s_stall}, {63'd0, exp_stall});
      n_valid = m_valid; n_mr = m_mr; n_known = m_data_known;
      n_opA = m_opA; n_opB = m_opB; n_imm = m_imm; n_Rd = m_Rd; n_ctrl = m_ctrl;
      n_cnt = m_cnt; n_scnt = m_scnt;
      if (reset) begin
         n_valid = 1'b0; n_mr = 1'b0; n_known = 1'b1;
         n_opA = '0; n_opB = '0; n_imm = '0; n_Rd = 5'd0; n_ctrl = '0;
         n_cnt = 0; n_scnt = 0;
      end else if (!hold) begin
         if (flush || hazard) begin
            n_valid = 1'b0; n_mr = 1'b0; n_ctrl = '0; n_known = 1'b0;
            if (!flush) begin
               n_cnt  = (m_cnt  + 1 > (1 << CNT)  - 1) ? m_cnt  : m_cnt + 1;
               n_scnt = (m_scnt + 1 > (1 << SCNT) - 1) ? m_scnt : m_scnt + 1;
            end
         end else begin
            n_valid = id_valid;
            n_mr    = id_valid && id_MemRead;
            n_ctrl  = id_valid ? id_ctrl : '0;
            n_opA   = pick(id_Rn, forwardA, id_rn_data);
            n_opB   = pick(id_Rm, forwardB, id_rm_data);
            n_imm   = id_imm;
            n_Rd    = id_Rd;
            n_known = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      m_valid = n_valid; m_mr = n_mr; m_data_known = n_known;
      m_opA = n_opA; m_opB = n_opB; m_imm = n_imm; m_Rd = n_Rd; m_ctrl = n_ctrl;
      m_cnt = n_cnt; m_scnt = n_scnt;
      check("ex_valid", {63'd0, ex_valid}, {63'd0, m_valid});
      check("ex_MemRead", {63'd0, ex_MemRead}, {63'd0, m_mr});
      check("ex_ctrl", {52'd0, ex_ctrl}, {52'd0, m_ctrl});
      check("loaduse_count", {48'd0, loaduse_count}, 64'(m_cnt));
      check("loaduse_count_small", {61'd0, s_loaduse_count}, 64'(m_scnt));
      if (m_data_known) begin
         check("ex_opA", ex_opA, m_opA);
         check("ex_opB", ex_opB, m_opB);
         check("ex_imm", ex_imm, m_imm);
         check("ex_Rd", {59'd0, ex_Rd}, {59'd0, m_Rd});
      end
   endtask

   // Put a fresh random instruction in ID with plain register-file operands
   task automatic set_id(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                         input logic mr);
      id_valid   = 1'b1;
      id_Rn      = rn;
      id_Rm      = rm;
      id_Rd      = rd;
      id_MemRead = mr;
      id_rn_data = {$urandom, $urandom};
      id_rm_data = {$urandom, $urandom};
      id_imm     = {$urandom, $urandom};
      id_ctrl    = 12'($urandom);
      forwardA   = 2'b00;
      forwardB   = 2'b00;
      flush      = 1'b0;
      hold       = 1'b0;
      reset      = 1'b0;
   endtask

   function automatic logic [4:0] rand_reg();
      logic [4:0] choices [4];
      choices[0] = 5'd3;
      choices[1] = 5'd5;
      choices[2] = 5'd31;
      choices[3] = 5'($urandom);
      return choices[$urandom_range(0, 3)];
   endfunction

   initial begin
      // Test 1: reset with every input nonzero
      reset = 1'b1; id_valid = 1'b1; id_Rn = 5'd7; id_Rm = 5'd9; id_Rd = 5'd4;
      id_rn_data = 64'h1111; id_rm_data = 64'h2222; id_imm = 64'h3333; id_ctrl = 12'hFFF;
      id_MemRead = 1'b1; forwardA = 2'b10; forwardB = 2'b01; ex_alu_result = 64'h44;
      mem_wb_result = 64'h66; mem_wb_link_addr = 64'h88; flush = 1'b1; hold = 1'b1;
      @(posedge clk); #1;
      step();
      check("t1_opA_zero", ex_opA, 64'd0);
      check("t1_count_zero", {48'd0, loaduse_count}, 64'd0);

      // Test 2: forward EX result to A and link address to B
      set_id(5'd3, 5'd30, 5'd8, 1'b0);
      forwardA = 2'b10; ex_alu_result = 64'h55;
      forwardB = 2'b11; mem_wb_link_addr = 64'h1004;
      step();
      check("t2_opA", ex_opA, 64'h55);
      check("t2_opB", ex_opB, 64'h1004);
      check("t2_valid", {63'd0, ex_valid}, 64'd1);

      // Test 3: load X5 then dependent ADD -> one bubble, then forward from MEM/WB
      set_id(5'd1, 5'd2, 5'd5, 1'b1);
      step();
      set_id(5'd5, 5'd2, 5'd7, 1'b0);
      step();
      check("t3_bubble_valid", {63'd0, ex_valid}, 64'd0);
      check("t3_count", {48'd0, loaduse_count}, 64'd1);
      forwardA = 2'b01; mem_wb_result = 64'hAB;
      step();
      check("t3_opA", ex_opA, 64'hAB);

      // Test 4: load to XZR, consumer reads XZR -> no stall and zero operand
      set_id(5'd1, 5'd2, 5'd31, 1'b1);
      step();
      set_id(5'd31, 5'd2, 5'd7, 1'b0);
      forwardA = 2'b10; ex_alu_result = 64'h77;
      step();
      check("t4_opA_zero", ex_opA, 64'd0);
      check("t4_valid", {63'd0, ex_valid}, 64'd1);

      // Test 5: load-use together with flush, then a 3-cycle hold with ID churning
      set_id(5'd1, 5'd2, 5'd5, 1'b1);
      step();
      set_id(5'd5, 5'd5, 5'd9, 1'b0);
      flush = 1'b1;
      step();
      check("t5_count_same", {48'd0, loaduse_count}, 64'd1);
      set_id(5'd10, 5'd11, 5'd12, 1'b1);
      step();
      for (int i = 0; i < 3; i++) begin
         set_id(rand_reg(), rand_reg(), rand_reg(), 1'($urandom));
         forwardA = 2'($urandom); forwardB = 2'($urandom);
         flush = (i == 1);
         hold  = 1'b1;
         step();
      end

      // Test 6: repeated load-use hazards; the 3-bit counter saturates
      for (int i = 0; i < 10; i++) begin
         set_id(5'd1, 5'd2, 5'd6, 1'b1);
         step();
         set_id(5'd4, 5'd6, 5'd7, 1'b0);
         step();
         forwardB = 2'b01;
         step();
      end
      check("t6_small_sat", {61'd0, s_loaduse_count}, 64'd7);

      // Reset while a stall is pending discards the stalled context
      set_id(5'd1, 5'd2, 5'd5, 1'b1);
      step();
      set_id(5'd5, 5'd2, 5'd7, 1'b0);
      reset = 1'b1;
      step();

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         set_id(rand_reg(), rand_reg(), rand_reg(), 1'($urandom_range(0, 1)));
         id_valid         = ($urandom_range(0, 9) != 0);
         forwardA         = 2'($urandom);
         forwardB         = 2'($urandom);
         ex_alu_result    = {$urandom, $urandom};
         mem_wb_result    = {$urandom, $urandom};
         mem_wb_link_addr = {$urandom, $urandom};
         flush            = ($urandom_range(0, 9) == 0);
         hold             = ($urandom_range(0, 6) == 0);
         reset            = ($urandom_range(0, 99) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline stage of the 5-stage LEGv8 pipeline. Sits directly downstream of the forwarding unit.
- Consumes its forwardA/forwardB selects and muxes the register-file read data with the EX result, MEM/WB result or MEM/WB link address.
- Registers the resolved operands, immediate, destination and control into the ID/EX pipeline register.
- Also owns load-use hazard detection (stall + bubble), branch flush, external hold, and a saturating load-use stall counter.

Parameters:
- WIDTH, 64, datapath width.
- CTRL_W, 12, width of the packed EX/MEM/WB control bundle carried through the stage.
- CNT_W, 16, width of the load-use stall counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  ID holds a real instruction.
- id_Rn  input  5  first source register.
- id_Rm  input  5  second source register.
- id_Rd  input  5  destination register.
- id_rn_data  input  WIDTH  register-file read for Rn.
- id_rm_data  input  WIDTH  register-file read for Rm.
- id_imm  input  WIDTH  sign-extended immediate.
- id_ctrl  input  CTRL_W  decoded control bundle.
- id_MemRead  input  1  instruction is a load.
- forwardA  input  2  Rn select from the forwarding unit.
- forwardB  input  2  Rm select from the forwarding unit.
- ex_alu_result  input  WIDTH  ALU output of the instruction currently in EX.
- mem_wb_result  input  WIDTH  value being written back from MEM/WB.
- mem_wb_link_addr  input  WIDTH  PC+4 of a BL in MEM/WB.
- flush  input  1  taken branch; discard the ID instruction.
- hold  input  1  global freeze (memory wait).
- stall  output  1  freeze PC and IF/ID (combinational).
- ex_valid  output  1  EX holds a real instruction.
- ex_opA  output  WIDTH  registered resolved Rn operand.
- ex_opB  output  WIDTH  registered resolved Rm operand.
- ex_imm  output  WIDTH  registered immediate.
- ex_Rd  output  5  registered destination.
- ex_ctrl  output  CTRL_W  registered control.
- ex_MemRead  output  1  registered load flag.
- loaduse_count  output  CNT_W  number of load-use bubbles inserted, saturating.

Behaviour:
Reset:
- reset=1 at an edge: all registered outputs go to 0 (ex_valid, ex_opA, ex_opB, ex_imm, ex_Rd, ex_ctrl, ex_MemRead, loaduse_count).
- stall is forced to 0 while reset is high.
- Reset mid-stall discards the stalled instruction's context; nothing is replayed.

Operand mux (combinational, evaluated in ID):
- Select encoding: 00 = id_*_data; 10 = ex_alu_result; 01 = mem_wb_result; 11 = mem_wb_link_addr.
- Applied independently to A (forwardA) and B (forwardB).
- XZR guard: if id_Rn==31, opA_next=0 regardless of forwardA. Same rule for Rm/opB.

Load-use detect (combinational):
- lu = id_valid & ex_valid & ex_MemRead & (ex_Rd!=31) & (ex_Rd==id_Rn | ex_Rd==id_Rm).
- stall = lu & ~flush & ~hold & ~reset.

Register update, priority reset > hold > flush > lu > normal:
- hold: every register keeps its value, including loaduse_count. stall=0, since hold freezes the pipe globally. A flush asserted during hold is ignored; its source must keep it high until hold drops.
- flush: ex_valid, ex_ctrl and ex_MemRead load 0 (bubble). Data fields are don't-care and load the mux outputs.
- lu: bubble loaded exactly as for flush; loaduse_count increments, saturating at 2^CNT_W-1. The next cycle the load is in MEM, lu deasserts, and the instruction proceeds with forward=01 supplied by the forwarding unit.
- normal: ex_valid←id_valid; ex_opA/B←mux outputs; ex_imm←id_imm; ex_Rd←id_Rd; ex_ctrl←id_ctrl; ex_MemRead←id_MemRead.
- An invalid ID instruction (id_valid=0) loads ex_ctrl=0 and ex_MemRead=0, so bubbles never write state.

Latency:
- 1 cycle from ID inputs to ex_* outputs.
- A load-use hazard adds exactly 1 bubble cycle.
- Back-to-back dependent loads each stall once.

Test Plan:
1. Reset with all inputs nonzero → next edge: every output 0, stall 0, loaduse_count 0.
2. forwardA=10, ex_alu_result=0x55, id_Rn=3; forwardB=11, mem_wb_link_addr=0x1004, id_Rm=30 → next cycle ex_opA=0x55, ex_opB=0x1004, ex_valid=1.
3. Load X5 in EX (ex_MemRead=1, ex_Rd=5); ADD with id_Rn=5 in ID → stall=1 that cycle, then bubble (ex_valid=0, ex_ctrl=0), loaduse_count=1. Next cycle: forwardA=01, mem_wb_result=0xAB → ex_opA=0xAB, stall=0.
4. Same as 3 but with ex_Rd=31 and id_Rn=31 → no stall, and ex_opA=0 even with forwardA=10.
5. Load-use and flush in the same cycle → stall=0, bubble inserted, loaduse_count unchanged. Then hold=1 for 3 cycles with ID inputs changing → all outputs frozen for those cycles.
6. Preload loaduse_count to 0xFFFE, create 3 load-use hazards → count reads 0xFFFF and stays there.
